// File: rtl/dmem_access_ctrl.sv
// Purpose: arbitrates two requesters (core, debug loader) onto one word-wide single-ported data memory.
// Latency: from accept, error response +1, store response +2 (write at +1), load response +3 (read issued at +1).
// Backpressure: req_ready only in IDLE for the round-robin winner; responses are one-cycle strobes, never stalled.
module dmem_access_ctrl #(
    parameter int MEM_WORDS_LOG2 = 12
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [1:0]                req_valid,
    output logic [1:0]                req_ready,
    input  logic [1:0]                req_we,
    input  logic [3:0]                req_size,
    input  logic [1:0]                req_unsigned,
    input  logic [63:0]               req_addr,
    input  logic [63:0]               req_wdata,
    output logic [1:0]                rsp_valid,
    output logic [31:0]               rsp_rdata,
    output logic                      rsp_err,
    output logic                      mem_en,
    output logic                      mem_we,
    output logic [3:0]                mem_be,
    output logic [MEM_WORDS_LOG2-1:0] mem_addr,
    output logic [31:0]               mem_wdata,
    input  logic [31:0]               mem_rdata
);

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    // Only the in-range part of the byte address is kept; out-of-range requests never reach memory.
    typedef struct packed {
        logic                      we;
        logic [1:0]                size;
        logic                      uns;
        logic [MEM_WORDS_LOG2+1:0] addr;
        logic [31:0]               wdata;
    } req_t;

    state_t      state;
    state_t      state_nxt;
    req_t        cur_q;
    req_t        sel_req;
    logic [31:0] sel_addr;
    logic        grant_sel;
    logic        grant_q;
    logic        last_grant_q;
    logic        sel_err;
    logic        err_q;
    logic        accept;
    logic [31:0] rdata_q;
    logic [31:0] load_fmt;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Round-robin winner selection and mux of the winner's payload.
    always_comb begin
        grant_sel = 1'b0;
        if (req_valid == 2'b11) begin
            grant_sel = ~last_grant_q;
        end else begin
            grant_sel = req_valid[1];
        end
        sel_addr      = grant_sel ? req_addr[63:32] : req_addr[31:0];
        sel_req.we    = grant_sel ? req_we[1] : req_we[0];
        sel_req.size  = grant_sel ? req_size[3:2] : req_size[1:0];
        sel_req.uns   = grant_sel ? req_unsigned[1] : req_unsigned[0];
        sel_req.addr  = sel_addr[MEM_WORDS_LOG2+1:0];
        sel_req.wdata = grant_sel ? req_wdata[63:32] : req_wdata[31:0];
        accept        = (state == IDLE) && (|req_valid);
    end

    // Size, alignment and range checks on the request currently being offered.
    always_comb begin
        sel_err = 1'b0;
        case (sel_req.size)
            SZ_BYTE: sel_err = 1'b0;
            SZ_HALF: sel_err = sel_addr[0];
            SZ_WORD: sel_err = |sel_addr[1:0];
            default: sel_err = 1'b1;
        endcase
        if ((sel_addr >> (MEM_WORDS_LOG2 + 2)) != 32'd0) begin
            sel_err = 1'b1;
        end
    end

    // Extract and extend the addressed byte/half from the read word returned in WAIT.
    always_comb begin
        case (cur_q.addr[1:0])
            2'd0:    byte_sel = mem_rdata[7:0];
            2'd1:    byte_sel = mem_rdata[15:8];
            2'd2:    byte_sel = mem_rdata[23:16];
            default: byte_sel = mem_rdata[31:24];
        endcase
        half_sel = cur_q.addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (cur_q.size)
            SZ_BYTE: load_fmt = {{24{~cur_q.uns & byte_sel[7]}}, byte_sel};
            SZ_HALF: load_fmt = {{16{~cur_q.uns & half_sel[15]}}, half_sel};
            default: load_fmt = mem_rdata;
        endcase
    end

    // Memory address and lane-replicated write data follow the latched request.
    always_comb begin
        mem_addr = cur_q.addr[MEM_WORDS_LOG2+1:2];
        case (cur_q.size)
            SZ_BYTE: mem_wdata = {4{cur_q.wdata[7:0]}};
            SZ_HALF: mem_wdata = {2{cur_q.wdata[15:0]}};
            default: mem_wdata = cur_q.wdata;
        endcase
    end

    // Next-state and per-state outputs.
    always_comb begin
        state_nxt = state;
        req_ready = 2'b00;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_be    = 4'b0000;
        rsp_valid = 2'b00;
        rsp_err   = 1'b0;
        rsp_rdata = 32'd0;
        case (state)
            IDLE: begin
                if (accept) begin
                    req_ready = grant_sel ? 2'b10 : 2'b01;
                    state_nxt = sel_err ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                mem_en = 1'b1;
                mem_we = cur_q.we;
                case (cur_q.size)
                    SZ_BYTE: mem_be = 4'b0001 << cur_q.addr[1:0];
                    SZ_HALF: mem_be = cur_q.addr[1] ? 4'b1100 : 4'b0011;
                    default: mem_be = 4'b1111;
                endcase
                state_nxt = cur_q.we ? RESP : WAIT;
            end
            WAIT: begin
                state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = grant_q ? 2'b10 : 2'b01;
                rsp_err   = err_q;
                rsp_rdata = rdata_q;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Request latch, arbitration history and load result register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_q        <= '0;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            err_q        <= 1'b0;
            rdata_q      <= 32'd0;
        end else begin
            if (accept) begin
                cur_q        <= sel_req;
                grant_q      <= grant_sel;
                last_grant_q <= grant_sel;
                err_q        <= sel_err;
                rdata_q      <= 32'd0;
            end
            if (state == WAIT) begin
                rdata_q <= load_fmt;
            end
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl: stores, loads, errors, arbitration and mid-transaction reset.
// Inputs change 1 time unit after the rising edge; outputs are sampled in the same window.
// The memory is modelled as a constant read word driven onto mem_rdata.
module tb_dmem_access_ctrl;

    localparam int MW = 12;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    req_valid;
    logic [1:0]    req_ready;
    logic [1:0]    req_we;
    logic [3:0]    req_size;
    logic [1:0]    req_unsigned;
    logic [63:0]   req_addr;
    logic [63:0]   req_wdata;
    logic [1:0]    rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic          mem_en;
    logic          mem_we;
    logic [3:0]    mem_be;
    logic [MW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    int checks = 0;
    int errors = 0;

    dmem_access_ctrl #(.MEM_WORDS_LOG2(MW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one request on port p and complete the handshake; waited = cycles spent before ready.
    task automatic send(input int p, input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd, output int waited);
        req_we[p]              = we;
        req_size[2*p +: 2]     = sz;
        req_unsigned[p]        = uns;
        req_addr[32*p +: 32]   = addr;
        req_wdata[32*p +: 32]  = wd;
        req_valid[p]           = 1'b1;
        waited = 0;
        #1;
        while (req_ready[p] !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        tick();
        req_valid[p] = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready got %b want 00", req_ready); end
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid got %b want 00", rsp_valid); end
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err got %b want 0", rsp_err); end
        checks++; if (rsp_rdata !== 32'd0) begin errors++; $display("FAIL reset_rsp_rdata got %h want 0", rsp_rdata); end
        checks++; if (mem_en !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_en_we got %b%b want 00", mem_en, mem_we); end
        checks++; if (mem_be !== 4'b0000) begin errors++; $display("FAIL reset_mem_be got %b want 0000", mem_be); end
        checks++; if (mem_addr !== 12'd0 || mem_wdata !== 32'd0) begin errors++; $display("FAIL reset_mem_addr_wdata got %h %h want 0 0", mem_addr, mem_wdata); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_store_word();
        int w;
        send(0, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, w);
        checks++; if (w != 0) begin errors++; $display("FAIL sw_ready_wait got %0d want 0", w); end
        checks++; if (mem_en !== 1'b1 || mem_we !== 1'b1) begin errors++; $display("FAIL sw_mem_en_we got %b%b want 11", mem_en, mem_we); end
        checks++; if (mem_be !== 4'b1111) begin errors++; $display("FAIL sw_mem_be got %b want 1111", mem_be); end
        checks++; if (mem_addr !== 12'd4) begin errors++; $display("FAIL sw_mem_addr got %h want 4", mem_addr); end
        checks++; if (mem_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_mem_wdata got %h want deadbeef", mem_wdata); end
        checks++; if (rsp_valid !== 2'b00 || req_ready !== 2'b00) begin errors++; $display("FAIL sw_t1_idle_outputs got %b %b want 00 00", rsp_valid, req_ready); end
        tick();
        checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL sw_rsp_valid got %b want 01", rsp_valid); end
        checks++; if (rsp_err !== 1'b0 || rsp_rdata !== 32'd0) begin errors++; $display("FAIL sw_rsp_err_rdata got %b %h want 0 0", rsp_err, rsp_rdata); end
        checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL sw_t2_mem_en got %b want 0", mem_en); end
        tick();
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL sw_t3_rsp_valid got %b want 00", rsp_valid); end
    endtask

    logic [31:0] ld_addr [5] = '{32'h13, 32'h13, 32'h12, 32'h12, 32'h10};
    logic [1:0]  ld_size [5] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2};
    logic        ld_uns  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [3:0]  ld_be   [5] = '{4'b1000, 4'b1000, 4'b1100, 4'b1100, 4'b1111};
    logic [31:0] ld_exp  [5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF, 32'h80FF1234};

    task automatic test_loads();
        int w;
        int p;
        mem_rdata = 32'h80FF_1234;
        for (int i = 0; i < 5; i++) begin
            p = (i == 4) ? 1 : 0;
            send(p, 1'b0, ld_size[i], ld_uns[i], ld_addr[i], 32'hFFFF_FFFF, w);
            checks++; if (w != 0) begin errors++; $display("FAIL ld%0d_ready_wait got %0d want 0", i, w); end
            checks++; if (mem_en !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("FAIL ld%0d_mem_en_we got %b%b want 10", i, mem_en, mem_we); end
            checks++; if (mem_be !== ld_be[i] || mem_addr !== 12'd4) begin errors++; $display("FAIL ld%0d_be_addr got %b %h want %b 4", i, mem_be, mem_addr, ld_be[i]); end
            tick();
            checks++; if (rsp_valid !== 2'b00 || mem_en !== 1'b0) begin errors++; $display("FAIL ld%0d_wait_state got %b %b want 00 0", i, rsp_valid, mem_en); end
            tick();
            checks++; if (rsp_valid !== (p == 1 ? 2'b10 : 2'b01)) begin errors++; $display("FAIL ld%0d_rsp_valid got %b want port %0d", i, rsp_valid, p); end
            checks++; if (rsp_rdata !== ld_exp[i] || rsp_err !== 1'b0) begin errors++; $display("FAIL ld%0d_rdata got %h err %b want %h err 0", i, rsp_rdata, rsp_err, ld_exp[i]); end
            tick();
        end
    endtask

    task automatic test_sub_stores();
        int w;
        send(0, 1'b1, 2'd0, 1'b0, 32'h21, 32'h0000_00AB, w);
        checks++; if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_be !== 4'b0010) begin errors++; $display("FAIL sb_ctrl got en%b we%b be%b want 1 1 0010", mem_en, mem_we, mem_be); end
        checks++; if (mem_wdata !== 32'hABABABAB || mem_addr !== 12'd8) begin errors++; $display("FAIL sb_data_addr got %h %h want ababab ab 8", mem_wdata, mem_addr); end
        tick();
        checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL sb_rsp_valid got %b want 01", rsp_valid); end
        tick();
        send(1, 1'b1, 2'd1, 1'b0, 32'h22, 32'h0000_1234, w);
        checks++; if (mem_en !== 1'b1 || mem_be !== 4'b1100) begin errors++; $display("FAIL sh_ctrl got en%b be%b want 1 1100", mem_en, mem_be); end
        checks++; if (mem_wdata !== 32'h12341234 || mem_addr !== 12'd8) begin errors++; $display("FAIL sh_data_addr got %h %h want 12341234 8", mem_wdata, mem_addr); end
        tick();
        checks++; if (rsp_valid !== 2'b10 || rsp_err !== 1'b0) begin errors++; $display("FAIL sh_rsp got %b err %b want 10 0", rsp_valid, rsp_err); end
        tick();
    endtask

    logic [31:0] er_addr [4] = '{32'h2, 32'h1, 32'h0, 32'h0000_4000};
    logic [1:0]  er_size [4] = '{2'd2, 2'd1, 2'd3, 2'd2};

    task automatic test_errors();
        int w;
        for (int i = 0; i < 4; i++) begin
            send(0, 1'b0, er_size[i], 1'b0, er_addr[i], 32'h0, w);
            checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL err%0d_mem_en got %b want 0", i, mem_en); end
            checks++; if (rsp_valid !== 2'b01 || rsp_err !== 1'b1) begin errors++; $display("FAIL err%0d_rsp got %b err %b want 01 1", i, rsp_valid, rsp_err); end
            checks++; if (rsp_rdata !== 32'd0) begin errors++; $display("FAIL err%0d_rdata got %h want 0", i, rsp_rdata); end
            tick();
            checks++; if (rsp_valid !== 2'b00 || mem_en !== 1'b0) begin errors++; $display("FAIL err%0d_after got %b %b want 00 0", i, rsp_valid, mem_en); end
        end
    endtask

    task automatic test_back_to_back();
        int n;
        int g;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req_we = 2'b11;
        req_size = 4'b1010;
        req_unsigned = 2'b00;
        req_addr = {32'h4, 32'h0};
        req_wdata = {32'h2222_2222, 32'h1111_1111};
        req_valid = 2'b11;
        #1;
        for (int k = 0; k < 4; k++) begin
            g = k % 2;
            n = 0;
            while (req_ready === 2'b00 && n < 10) begin
                tick();
                n++;
            end
            checks++; if (req_ready !== (g == 1 ? 2'b10 : 2'b01)) begin errors++; $display("FAIL rr%0d_grant got %b want port %0d", k, req_ready, g); end
            tick();
            checks++; if (mem_addr !== MW'(g) || mem_wdata !== (g == 1 ? 32'h22222222 : 32'h11111111)) begin errors++; $display("FAIL rr%0d_mem got %h %h want port %0d", k, mem_addr, mem_wdata, g); end
            checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rr%0d_busy_ready got %b want 00", k, req_ready); end
            tick();
            checks++; if (rsp_valid !== (g == 1 ? 2'b10 : 2'b01)) begin errors++; $display("FAIL rr%0d_rsp_valid got %b want port %0d", k, rsp_valid, g); end
            tick();
        end
        req_valid = 2'b00;
        tick();
    endtask

    task automatic test_reset_mid();
        int w;
        mem_rdata = 32'h5555_AAAA;
        send(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, w);
        checks++; if (mem_en !== 1'b1) begin errors++; $display("FAIL rst_mid_access got %b want 1", mem_en); end
        tick();
        reset = 1'b1;
        tick();
        checks++; if (rsp_valid !== 2'b00 || mem_en !== 1'b0 || rsp_err !== 1'b0) begin errors++; $display("FAIL rst_mid_abort got %b %b %b want 00 0 0", rsp_valid, mem_en, rsp_err); end
        reset = 1'b0;
        req_we = 2'b11;
        req_size = 4'b1010;
        req_addr = {32'h8, 32'h0};
        req_valid = 2'b10;
        #1;
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL rst_mid_req1_alone got %b want 10", req_ready); end
        req_valid = 2'b11;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rst_mid_tie got %b want 01", req_ready); end
        req_valid = 2'b00;
        tick();
        tick();
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rst_mid_no_stray_rsp got %b want 00", rsp_valid); end
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 2'b00;
        req_we = 2'b00;
        req_size = 4'b0000;
        req_unsigned = 2'b00;
        req_addr = 64'd0;
        req_wdata = 64'd0;
        mem_rdata = 32'd0;
        #1;
        test_reset();
        test_store_word();
        test_loads();
        test_sub_stores();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
